// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch controller.
// The optional call/return stack is enabled by defining FETCH_CALL_RET_EN.
package fetch_pkg;

   localparam int ADDR_W      = 8;
   localparam int INSTR_W     = 16;
   localparam int STACK_DEPTH = 4;
   localparam int STACK_PTR_W = 2;

   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_CALL = 4'hD;
   localparam logic [3:0] OP_RET  = 4'hE;

   localparam logic [0:0] ST_FETCH = 1'b0;
   localparam logic [0:0] ST_ISSUE = 1'b1;

   typedef logic [ADDR_W-1:0]  addr_t;
   typedef logic [INSTR_W-1:0] instr_t;

   // Observation port: FSM state plus return-stack occupancy flags.
   typedef struct packed {
      logic [0:0] state;
      logic       stack_empty;
      logic       stack_full;
   } fetch_dbg_t;

   function automatic logic [3:0] opcode_of(input instr_t word);
      return word[INSTR_W-1:INSTR_W-4];
   endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Memory read bus and decode issue handshake of the fetch controller.
interface fetch_ctrl_if;
   import fetch_pkg::*;

   // memReq/memReady: memReq holds with a stable memAddr until the cycle
   // memReady=1; memData is valid in that same cycle.
   // instrValid/instrReady: instr is transferred in a cycle where both are 1;
   // while instrValid=1 and instrReady=0, instr holds its value.
   logic   memReq;
   addr_t  memAddr;
   logic   memReady;
   instr_t memData;
   logic   instrValid;
   instr_t instr;
   logic   instrReady;

   modport master (
      output memReq, memAddr, instrValid, instr,
      input  memReady, memData, instrReady
   );

   modport slave (
      input  memReq, memAddr, instrValid, instr,
      output memReady, memData, instrReady
   );

endinterface

// File: rtl/fetch_ctrl_ret_stack.sv
// Four-entry circular return-address stack; only built when FETCH_CALL_RET_EN
// is defined. A push when full overwrites the oldest entry; popping empty reads 0.
module ret_stack
   import fetch_pkg::*;
(
   input  logic  clk,
   input  logic  resetN,
   input  logic  push,
   input  logic  pop,
   input  addr_t din,
   output addr_t dout,
   output logic  empty,
   output logic  full
);

   addr_t                  mem [STACK_DEPTH];
   logic [STACK_PTR_W-1:0] top;
   logic [STACK_PTR_W:0]   count;

   assign empty = (count == '0);
   assign full  = (count == (STACK_PTR_W+1)'(STACK_DEPTH));
   assign dout  = empty ? '0 : mem[top];

   // Pointer wrap is what overwrites the oldest entry once the stack is full.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         top   <= '0;
         count <= '0;
         for (int i = 0; i < STACK_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[top + 1'b1] <= din;
         top             <= top + 1'b1;
         if (!full) begin
            count <= count + 1'b1;
         end
      end else if (pop && !empty) begin
         top   <= top - 1'b1;
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: fetches one word at pcValue, issues it to
// decode, then steers the PC. Define FETCH_CALL_RET_EN for CALL/RET support.
module fetch_ctrl
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        resetN,
   input  addr_t       pcValue,
   output logic        pcHold,
   output logic        pcJump,
   output addr_t       pcJumpLine,
   input  logic        exJump,
   input  addr_t       exTarget,
   fetch_ctrl_if.master bus,
   output fetch_dbg_t  dbg
);

   logic [0:0] state;
   logic [0:0] state_nxt;
   instr_t     instr_q;
   logic       fetch_st;
   logic       issue_st;
   logic       capture;
   logic       accept;
   logic [3:0] op;
   logic       stack_empty;
   logic       stack_full;

   assign fetch_st = resetN && (state == ST_FETCH);
   assign issue_st = resetN && (state == ST_ISSUE);
   // A redirect in the same cycle wins over both capture and accept.
   assign capture  = fetch_st && bus.memReady && !exJump;
   assign accept   = issue_st && bus.instrReady && !exJump;
   assign op       = opcode_of(instr_q);

`ifdef FETCH_CALL_RET_EN
   logic  is_call;
   logic  is_ret;
   addr_t ret_addr;

   assign is_call = accept && (op == OP_CALL);
   assign is_ret  = accept && (op == OP_RET);

   ret_stack u_ret_stack (
      .clk    (clk),
      .resetN (resetN),
      .push   (is_call),
      .pop    (is_ret),
      .din    (pcValue + 8'd1),
      .dout   (ret_addr),
      .empty  (stack_empty),
      .full   (stack_full)
   );
`else
   assign stack_empty = 1'b1;
   assign stack_full  = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      if (exJump) begin
         state_nxt = ST_FETCH;
      end else if (capture) begin
         state_nxt = ST_ISSUE;
      end else if (accept) begin
         state_nxt = ST_FETCH;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state   <= ST_FETCH;
         instr_q <= '0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            instr_q <= bus.memData;
         end
      end
   end

   // PC steering: hold by default, release for exactly one cycle per accept.
   always_comb begin
      pcHold     = 1'b1;
      pcJump     = 1'b0;
      pcJumpLine = '0;
      if (resetN && exJump) begin
         pcJump     = 1'b1;
         pcJumpLine = exTarget;
      end else if (accept) begin
         case (op)
            OP_JMP: begin
               pcJump     = 1'b1;
               pcJumpLine = instr_q[ADDR_W-1:0];
            end
`ifdef FETCH_CALL_RET_EN
            OP_CALL: begin
               pcJump     = 1'b1;
               pcJumpLine = instr_q[ADDR_W-1:0];
            end
            OP_RET: begin
               pcJump     = 1'b1;
               pcJumpLine = ret_addr;
            end
`endif
            default: begin
               pcHold = 1'b0;
            end
         endcase
      end
   end

   assign bus.memReq     = fetch_st;
   assign bus.memAddr    = resetN ? pcValue : '0;
   assign bus.instrValid = issue_st;
   assign bus.instr      = instr_q;

   assign dbg.state       = state;
   assign dbg.stack_empty = stack_empty;
   assign dbg.stack_full  = stack_full;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios, then randomized traffic against
// a behavioural model of the fetch/issue/redirect rules and the return stack.
module tb_fetch_ctrl;
   import fetch_pkg::*;

   logic       clk = 1'b0;
   logic       resetN;
   logic [7:0] pcValue;
   logic       pcHold;
   logic       pcJump;
   logic [7:0] pcJumpLine;
   logic       exJump;
   logic [7:0] exTarget;
   fetch_dbg_t dbg;

   fetch_ctrl_if bus ();

   fetch_ctrl dut (
      .clk        (clk),
      .resetN     (resetN),
      .pcValue    (pcValue),
      .pcHold     (pcHold),
      .pcJump     (pcJump),
      .pcJumpLine (pcJumpLine),
      .exJump     (exJump),
      .exTarget   (exTarget),
      .bus        (bus),
      .dbg        (dbg)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   logic [7:0]  stk[$];
   logic [15:0] imem [256];
   logic        m_valid;
   logic [15:0] m_instr;
   logic        ej;
   logic        eh;
   logic [7:0]  el;
   logic        mj;
   logic        mh;
   logic [7:0]  ml;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock edge; the bench plays the PC register using the DUT's steering.
   task automatic tick();
      logic       j;
      logic       h;
      logic [7:0] jl;
      j  = pcJump;
      h  = pcHold;
      jl = pcJumpLine;
      @(posedge clk);
      #1;
      if (j) pcValue = jl;
      else if (!h) pcValue = pcValue + 8'd1;
   endtask

   // Architectural effect of accepting word w fetched from address pc.
   task automatic model_accept(input logic [15:0] w, input logic [7:0] pc,
                               output logic j, output logic [7:0] l, output logic h);
      j = 1'b1;
      h = 1'b1;
      l = w[7:0];
      case (w[15:12])
         4'hC: ;
`ifdef FETCH_CALL_RET_EN
         4'hD: begin
            stk.push_back(8'(pc + 8'd1));
            if (stk.size() > 4) void'(stk.pop_front());
         end
         4'hE: l = (stk.size() > 0) ? stk.pop_back() : 8'h00;
`endif
         default: begin
            j = 1'b0;
            h = 1'b0;
            l = 8'h00;
         end
      endcase
   endtask

   task automatic run_instr(input string tag, input logic [15:0] w,
                            input logic exp_j, input logic [7:0] exp_l, input logic exp_h);
      bus.memReady   = 1'b1;
      bus.memData    = w;
      bus.instrReady = 1'b1;
      exJump         = 1'b0;
      #1;
      chk({tag, "_memreq"}, 16'(bus.memReq), 16'h1);
      chk({tag, "_addr"}, 16'(bus.memAddr), 16'(pcValue));
      tick();
      bus.memReady = 1'b0;
      #1;
      chk({tag, "_valid"}, 16'(bus.instrValid), 16'h1);
      chk({tag, "_instr"}, bus.instr, w);
      chk({tag, "_jump"}, 16'(pcJump), 16'(exp_j));
      if (exp_j) chk({tag, "_line"}, 16'(pcJumpLine), 16'(exp_l));
      else chk({tag, "_hold"}, 16'(pcHold), 16'(exp_h));
      tick();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_memreq"}, 16'(bus.memReq), 16'h0);
      chk({tag, "_addr"}, 16'(bus.memAddr), 16'h0);
      chk({tag, "_hold"}, 16'(pcHold), 16'h1);
      chk({tag, "_jump"}, 16'(pcJump), 16'h0);
      chk({tag, "_line"}, 16'(pcJumpLine), 16'h0);
      chk({tag, "_valid"}, 16'(bus.instrValid), 16'h0);
      chk({tag, "_instr"}, bus.instr, 16'h0);
   endtask

   initial begin
      resetN         = 1'b0;
      pcValue        = 8'h10;
      exJump         = 1'b0;
      exTarget       = 8'h00;
      bus.memReady   = 1'b0;
      bus.memData    = 16'h0;
      bus.instrReady = 1'b0;
      #2;
      chk_reset_outputs("rst");
      chk("rst_state", 16'(dbg.state), 16'(ST_FETCH));
      @(posedge clk);
      #1;
      resetN = 1'b1;

      // First fetch accepted immediately, ordinary instruction advances PC.
      bus.memReady = 1'b1; bus.memData = 16'h1234; bus.instrReady = 1'b1;
      #1;
      chk("f1_memreq", 16'(bus.memReq), 16'h1);
      chk("f1_addr", 16'(bus.memAddr), 16'h10);
      chk("f1_hold", 16'(pcHold), 16'h1);
      chk("f1_jump", 16'(pcJump), 16'h0);
      chk("f1_valid", 16'(bus.instrValid), 16'h0);
      tick();
      bus.memReady = 1'b0;
      #1;
      chk("i1_valid", 16'(bus.instrValid), 16'h1);
      chk("i1_instr", bus.instr, 16'h1234);
      chk("i1_state", 16'(dbg.state), 16'(ST_ISSUE));
      chk("i1_memreq", 16'(bus.memReq), 16'h0);
      chk("i1_hold", 16'(pcHold), 16'h0);
      chk("i1_jump", 16'(pcJump), 16'h0);
      tick();
      chk("adv_pc", 16'(pcValue), 16'h11);

      // Memory stalls three cycles; request and address must hold.
      bus.instrReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_memreq", 16'(bus.memReq), 16'h1);
         chk("stall_addr", 16'(bus.memAddr), 16'h11);
         chk("stall_hold", 16'(pcHold), 16'h1);
         chk("stall_jump", 16'(pcJump), 16'h0);
         tick();
      end
      bus.memReady = 1'b1; bus.memData = 16'hC042;
      #1;
      chk("stall_addr4", 16'(bus.memAddr), 16'h11);
      tick();
      bus.memReady = 1'b0;
      #1;
      chk("jmp_wait_valid", 16'(bus.instrValid), 16'h1);
      chk("jmp_wait_hold", 16'(pcHold), 16'h1);
      chk("jmp_wait_jump", 16'(pcJump), 16'h0);
      tick();
      bus.instrReady = 1'b1;
      #1;
      chk("jmp_instr", bus.instr, 16'hC042);
      chk("jmp_jump", 16'(pcJump), 16'h1);
      chk("jmp_line", 16'(pcJumpLine), 16'h42);
      tick();
      #1;
      chk("jmp_pc", 16'(pcValue), 16'h42);
      chk("jmp_once", 16'(pcJump), 16'h0);

      // Redirect coinciding with memReady discards the returned word.
      bus.memReady = 1'b1; bus.memData = 16'h5555; exJump = 1'b1; exTarget = 8'h80;
      #1;
      chk("exj_jump", 16'(pcJump), 16'h1);
      chk("exj_line", 16'(pcJumpLine), 16'h80);
      tick();
      bus.memReady = 1'b0; exJump = 1'b0;
      #1;
      chk("exj_valid", 16'(bus.instrValid), 16'h0);
      chk("exj_memreq", 16'(bus.memReq), 16'h1);
      chk("exj_addr", 16'(bus.memAddr), 16'h80);
      tick();
      #1;
      chk("exj_valid2", 16'(bus.instrValid), 16'h0);

      // CALL at 0x05 then RET, and a stack overflow sequence.
      exJump = 1'b1; exTarget = 8'h05;
      #1;
      tick();
      exJump = 1'b0;
      chk("call_pc", 16'(pcValue), 16'h05);
`ifdef FETCH_CALL_RET_EN
      run_instr("call", 16'hD020, 1'b1, 8'h20, 1'b1);
      chk("call_tgt", 16'(pcValue), 16'h20);
      run_instr("ret", 16'hE000, 1'b1, 8'h06, 1'b1);
      chk("ret_tgt", 16'(pcValue), 16'h06);
`else
      run_instr("call", 16'hD020, 1'b0, 8'h00, 1'b0);
      chk("call_tgt", 16'(pcValue), 16'h06);
      run_instr("ret", 16'hE000, 1'b0, 8'h00, 1'b0);
      chk("ret_tgt", 16'(pcValue), 16'h07);
`endif
      stk.delete();
      for (int i = 0; i < 5; i++) begin
         model_accept({8'hD0, 8'(8'h40 + i)}, pcValue, mj, ml, mh);
         run_instr("call5", {8'hD0, 8'(8'h40 + i)}, mj, ml, mh);
      end
      for (int i = 0; i < 5; i++) begin
         model_accept(16'hE000, pcValue, mj, ml, mh);
         run_instr("ret5", 16'hE000, mj, ml, mh);
      end
`ifdef FETCH_CALL_RET_EN
      chk("ret5_empty_pc", 16'(pcValue), 16'h00);
`endif

      // Stalled issue interrupted by an asynchronous reset.
      bus.memReady = 1'b1; bus.memData = 16'h0ABC; bus.instrReady = 1'b0;
      #1;
      tick();
      bus.memReady = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("hold_valid", 16'(bus.instrValid), 16'h1);
         chk("hold_instr", bus.instr, 16'h0ABC);
         tick();
      end
      resetN = 1'b0;
      #1;
      chk_reset_outputs("arst");
      stk.delete();
      tick();
      resetN  = 1'b1;
      pcValue = 8'($urandom);

      // Randomized traffic against the behavioural model.
      for (int i = 0; i < 256; i++) begin
         case ($urandom_range(0, 5))
            0:       imem[i] = {4'hC, 4'($urandom), 8'($urandom)};
            1:       imem[i] = {4'hD, 4'($urandom), 8'($urandom)};
            2:       imem[i] = {4'hE, 12'($urandom)};
            default: imem[i] = 16'($urandom);
         endcase
      end
      m_valid = 1'b0;
      m_instr = 16'h0;
      for (int c = 0; c < 800; c++) begin
         bus.memReady   = ($urandom_range(0, 3) != 0);
         bus.memData    = imem[pcValue];
         bus.instrReady = ($urandom_range(0, 2) != 0);
         exJump         = ($urandom_range(0, 19) == 0);
         exTarget       = 8'($urandom);
         #1;
         chk("r_valid", 16'(bus.instrValid), 16'(m_valid));
         if (m_valid) chk("r_instr", bus.instr, m_instr);
         chk("r_memreq", 16'(bus.memReq), 16'(!m_valid));
         chk("r_addr", 16'(bus.memAddr), 16'(pcValue));
         ej = 1'b0; eh = 1'b1; el = 8'h00;
         if (exJump) begin
            ej = 1'b1; el = exTarget; m_valid = 1'b0;
         end else if (m_valid && bus.instrReady) begin
            model_accept(m_instr, pcValue, ej, el, eh);
            m_valid = 1'b0;
         end else if (!m_valid && bus.memReady) begin
            m_valid = 1'b1;
            m_instr = bus.memData;
         end
         chk("r_jump", 16'(pcJump), 16'(ej));
         if (ej) chk("r_line", 16'(pcJumpLine), 16'(el));
         else chk("r_hold", 16'(pcHold), 16'(eh));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
